// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } booth_state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Unsigned operands need one extra digit so the zero-extended MSB is covered.
    function automatic int unsigned booth_digits(input logic is_signed, input int unsigned width);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// rtl/booth_digit_enc.sv - radix-4 Booth recoder for one overlapping 3-bit multiplier window
import booth_pkg::*;

module booth_digit_enc (
    input  logic [2:0]   bits,
    output booth_digit_t digit
);

    always_comb begin
        digit.neg = bits[2] & ~(bits[1] & bits[0]);
        digit.one = bits[1] ^ bits[0];
        digit.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - iterative radix-4 Booth multiplier, one digit per clock
import booth_pkg::*;

module booth_mult_seq #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    input  logic                 approx,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH / 2 + 2);
    localparam logic [ACC_W-1:0] APPROX_MASK = {ACC_W{1'b1}} << APPROX_BITS;

    booth_state_t     state_q, state_d;
    logic [ACC_W-1:0] x_q, x_d;
    logic [EXT_W:0]   y_q, y_d;
    logic             signed_q, signed_d;
    logic             approx_q, approx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    booth_digit_t     digit;
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] term;
    logic [CNT_W-1:0] last_cnt;

    // y_q keeps the implicit y[-1] in bit 0, so the low three bits are always the current window.
    booth_digit_enc u_digit_enc (
        .bits  (y_q[2:0]),
        .digit (digit)
    );

    // x_q already carries the 4^i weight, so no barrel shifter is needed.
    always_comb begin
        mag = '0;
        if (digit.two) begin
            mag = x_q << 1;
        end else if (digit.one) begin
            mag = x_q;
        end
        term = digit.neg ? (~mag + ACC_W'(1)) : mag;
        if (approx_q) begin
            term = term & APPROX_MASK;
        end
    end

    assign last_cnt = CNT_W'(booth_digits(signed_q, WIDTH) - 1);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        approx_d = approx_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = {{(ACC_W - WIDTH){x[WIDTH-1] & is_signed}}, x};
                    y_d      = {{2{y[WIDTH-1] & is_signed}}, y, 1'b0};
                    signed_d = is_signed;
                    approx_d = approx;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + term;
                x_d   = x_q << 2;
                y_d   = {{2{y_q[EXT_W]}}, y_q[EXT_W:2]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            approx_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            approx_q <= approx_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign p         = acc_q[2*WIDTH-1:0];

endmodule
